des_key_schedule: RTL and testbench

Parametrised successor to the single-round branch-key generator. It expands one 64-bit DES key into all 16 48-bit round keys (PC-1, per-round left rotation, PC-2) and stores them in an internal 16-entry key table. A registered read port serves keys in encrypt order (K1..K16) or decrypt order (K16..K1). It sits between key loading and the DES round datapath, so the round engine never waits on per-round key regeneration.

---
 rtl/des_key_schedule_if.sv | 23 ++
 rtl/des_key_schedule.sv | 180 ++++++++++++++++++
 tb/tb_des_key_schedule.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/des_key_schedule_if.sv
// Key-load and round-key read bus between the key loader, the DES round
// engine and des_key_schedule.
interface des_key_schedule_if;
    logic        start;
    logic [1:64] key_in;
    logic        busy;
    logic        ready;
    logic        rd_en;
    logic [3:0]  rd_idx;
    logic        rd_dec;
    logic        rd_valid;
    logic [1:48] rd_key;

    modport master (
        output start, key_in, rd_en, rd_idx, rd_dec,
        input  busy, ready, rd_valid, rd_key
    );

    modport slave (
        input  start, key_in, rd_en, rd_idx, rd_dec,
        output busy, ready, rd_valid, rd_key
    );
endinterface

// File: rtl/des_key_schedule.sv
// DES key schedule: expands one 64-bit key into 16 round keys held in a table,
// KEYS_PER_CYCLE rounds per cycle, with a registered encrypt/decrypt-order read port.
module des_key_schedule #(
    parameter int unsigned KEYS_PER_CYCLE = 1,
    parameter int unsigned CLEAR_ON_START = 1
) (
    input  logic                clk,
    input  logic                rst,
    des_key_schedule_if.slave   bus
);

    localparam int unsigned KPC        = KEYS_PER_CYCLE;
    localparam int unsigned NUM_ROUNDS = 16;
    localparam int unsigned RND_W      = 5;

    if (!(KPC == 1 || KPC == 2 || KPC == 4 || KPC == 8 || KPC == 16)) begin : g_bad_kpc
        $error("des_key_schedule: KEYS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GEN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_load;
    logic             w_step;
    logic             w_last;

    logic [1:28]      r_c;
    logic [1:28]      r_d;
    logic [RND_W-1:0] r_rnd;
    logic             r_busy;
    logic             r_ready;
    logic             r_rd_valid;
    logic [1:48]      r_rd_key;

    logic [1:56]      w_pc1;
    logic [1:28]      w_c_st [KPC+1];
    logic [1:28]      w_d_st [KPC+1];
    logic [1:48]      w_keys [KPC];
    logic [1:48]      w_table [NUM_ROUNDS];
    logic [3:0]       w_rd_sel;

    function automatic logic [1:56] f_pc1(input logic [1:64] k);
        return {k[57], k[49], k[41], k[33], k[25], k[17], k[9],
                k[1],  k[58], k[50], k[42], k[34], k[26], k[18],
                k[10], k[2],  k[59], k[51], k[43], k[35], k[27],
                k[19], k[11], k[3],  k[60], k[52], k[44], k[36],
                k[63], k[55], k[47], k[39], k[31], k[23], k[15],
                k[7],  k[62], k[54], k[46], k[38], k[30], k[22],
                k[14], k[6],  k[61], k[53], k[45], k[37], k[29],
                k[21], k[13], k[5],  k[28], k[20], k[12], k[4]};
    endfunction

    function automatic logic [1:48] f_pc2(input logic [1:56] cd);
        return {cd[14], cd[17], cd[11], cd[24], cd[1],  cd[5],
                cd[3],  cd[28], cd[15], cd[6],  cd[21], cd[10],
                cd[23], cd[19], cd[12], cd[4],  cd[26], cd[8],
                cd[16], cd[7],  cd[27], cd[20], cd[13], cd[2],
                cd[41], cd[52], cd[31], cd[37], cd[47], cd[55],
                cd[30], cd[40], cd[51], cd[45], cd[33], cd[48],
                cd[44], cd[49], cd[39], cd[56], cd[34], cd[53],
                cd[46], cd[42], cd[50], cd[36], cd[29], cd[32]};
    endfunction

    assign w_pc1 = f_pc1(bus.key_in);

    // Combinational chain of KPC rounds starting from the registered C/D halves
    assign w_c_st[0] = r_c;
    assign w_d_st[0] = r_d;

    for (genvar g = 0; g < KPC; g++) begin : g_round
        logic [RND_W-1:0] w_num;
        logic             w_single;

        assign w_num    = r_rnd + RND_W'(g + 1);
        assign w_single = (w_num == 5'd1) || (w_num == 5'd2) ||
                          (w_num == 5'd9) || (w_num == 5'd16);

        assign w_c_st[g+1] = w_single ? {w_c_st[g][2:28], w_c_st[g][1]}
                                      : {w_c_st[g][3:28], w_c_st[g][1:2]};
        assign w_d_st[g+1] = w_single ? {w_d_st[g][2:28], w_d_st[g][1]}
                                      : {w_d_st[g][3:28], w_d_st[g][1:2]};
        assign w_keys[g]   = f_pc2({w_c_st[g+1], w_d_st[g+1]});
    end

    // Entry e is produced by lane e%KPC in the cycle where r_rnd equals its group base
    for (genvar e = 0; e < NUM_ROUNDS; e++) begin : g_entry
        localparam int unsigned BASE = (e / KPC) * KPC;
        localparam int unsigned LANE = e % KPC;

        logic [1:48] r_entry;
        logic        w_we;

        assign w_we = w_step && (r_rnd == RND_W'(BASE));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_entry <= '0;
            end else if (w_load && (CLEAR_ON_START != 0)) begin
                r_entry <= '0;
            end else if (w_we) begin
                r_entry <= w_keys[LANE];
            end
        end

        assign w_table[e] = r_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (bus.start) w_state_nxt = S_GEN;
            S_GEN:          if (w_last)    w_state_nxt = S_DONE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_load = 1'b0;
        w_step = 1'b0;
        w_last = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: w_load = bus.start;
            S_GEN: begin
                w_step = 1'b1;
                w_last = ((r_rnd + RND_W'(KPC)) == RND_W'(NUM_ROUNDS));
            end
            default: ;
        endcase
    end

    assign w_rd_sel = bus.rd_dec ? 4'(4'd15 - bus.rd_idx) : bus.rd_idx;

    // C/D halves, round counter, status flags and read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c        <= '0;
            r_d        <= '0;
            r_rnd      <= '0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_key   <= '0;
        end else begin
            if (w_load) begin
                r_c   <= w_pc1[1:28];
                r_d   <= w_pc1[29:56];
                r_rnd <= '0;
            end else if (w_step) begin
                r_c   <= w_c_st[KPC];
                r_d   <= w_d_st[KPC];
                r_rnd <= r_rnd + RND_W'(KPC);
            end
            r_busy     <= (w_state_nxt == S_GEN);
            r_ready    <= (w_state_nxt == S_DONE);
            r_rd_valid <= bus.rd_en && r_ready;
            if (bus.rd_en && r_ready) begin
                r_rd_key <= w_table[w_rd_sel];
            end
        end
    end

    assign bus.busy     = r_busy;
    assign bus.ready    = r_ready;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_key   = r_rd_key;

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: K=1, 4 and 16 instances, directed vectors
// using the classic 133457799BBCDFF1 key schedule.
module tb_des_key_schedule;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    des_key_schedule_if if1 ();
    des_key_schedule_if if4 ();
    des_key_schedule_if if16 ();

    des_key_schedule #(.KEYS_PER_CYCLE(1),  .CLEAR_ON_START(1)) dut1  (.clk(clk), .rst(rst), .bus(if1));
    des_key_schedule #(.KEYS_PER_CYCLE(4),  .CLEAR_ON_START(1)) dut4  (.clk(clk), .rst(rst), .bus(if4));
    des_key_schedule #(.KEYS_PER_CYCLE(16), .CLEAR_ON_START(1)) dut16 (.clk(clk), .rst(rst), .bus(if16));

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;
    localparam logic [27:0] C0_A  = 28'hF0CCAAF;
    localparam logic [27:0] D0_A  = 28'h556678F;

    localparam logic [47:0] KTAB [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    int checks = 0;
    int errors = 0;
    logic [47:0] q1 [$];
    logic [47:0] q4 [$];
    logic [47:0] q16 [$];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_rd(input int d, input logic en, input logic [3:0] idx, input logic dec);
        case (d)
            1:  begin if1.rd_en  = en; if1.rd_idx  = idx; if1.rd_dec  = dec; end
            4:  begin if4.rd_en  = en; if4.rd_idx  = idx; if4.rd_dec  = dec; end
            16: begin if16.rd_en = en; if16.rd_idx = idx; if16.rd_dec = dec; end
            default: ;
        endcase
    endtask

    task automatic read(input int d, input logic [3:0] idx, input logic dec, input logic [47:0] exp);
        case (d)
            1:  q1.push_back(exp);
            4:  q4.push_back(exp);
            16: q16.push_back(exp);
            default: ;
        endcase
        set_rd(d, 1'b1, idx, dec);
    endtask

    task automatic clear_rd();
        set_rd(1, 1'b0, 4'd0, 1'b0);
        set_rd(4, 1'b0, 4'd0, 1'b0);
        set_rd(16, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic wait_ready1(input int c0, output int c);
        c = c0;
        while (!if1.ready && c < 40) begin
            tick();
            c++;
        end
    endtask

    // Pops the expected key whenever an instance presents rd_valid
    task automatic monitor();
        logic [47:0] e;
        forever begin
            @(negedge clk);
            if (if1.rd_valid) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected_k1: got valid key %h expected no read", if1.rd_key);
                end else begin
                    e = q1.pop_front();
                    chk("rd_key_k1", 64'(if1.rd_key), 64'(e));
                end
            end
            if (if4.rd_valid) begin
                if (q4.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected_k4: got valid key %h expected no read", if4.rd_key);
                end else begin
                    e = q4.pop_front();
                    chk("rd_key_k4", 64'(if4.rd_key), 64'(e));
                end
            end
            if (if16.rd_valid) begin
                if (q16.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected_k16: got valid key %h expected no read", if16.rd_key);
                end else begin
                    e = q16.pop_front();
                    chk("rd_key_k16", 64'(if16.rd_key), 64'(e));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c, f1, f4, f16;

        rst = 1'b1;
        if1.start = 1'b0;  if1.key_in = '0;
        if4.start = 1'b0;  if4.key_in = '0;
        if16.start = 1'b0; if16.key_in = '0;
        clear_rd();
        fork
            monitor();
        join_none
        repeat (3) tick();
        chk("reset_busy",     64'(if1.busy), 64'd0);
        chk("reset_ready",    64'(if1.ready), 64'd0);
        chk("reset_rd_valid", 64'(if1.rd_valid), 64'd0);
        chk("reset_rd_key",   64'(if1.rd_key), 64'd0);
        rst = 1'b0;
        tick();

        // Parallel expansion on all three instances: latency per KEYS_PER_CYCLE
        if1.key_in = KEY_A; if4.key_in = KEY_A; if16.key_in = KEY_A;
        if1.start = 1'b1;   if4.start = 1'b1;   if16.start = 1'b1;
        tick();
        if1.start = 1'b0;   if4.start = 1'b0;   if16.start = 1'b0;
        chk("busy_after_start_k1",  64'(if1.busy), 64'd1);
        chk("busy_after_start_k16", 64'(if16.busy), 64'd1);
        chk("ready_after_start_k1", 64'(if1.ready), 64'd0);
        f1 = 0; f4 = 0; f16 = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (if1.ready && f1 == 0)   f1 = i;
            if (if4.ready && f4 == 0)   f4 = i;
            if (if16.ready && f16 == 0) f16 = i;
            if (i == 15) chk("busy_k1_cycle15", 64'(if1.busy), 64'd1);
            if (i == 16) chk("busy_k1_cycle16", 64'(if1.busy), 64'd0);
        end
        chk("latency_k1",  64'(f1),  64'd16);
        chk("latency_k4",  64'(f4),  64'd4);
        chk("latency_k16", 64'(f16), 64'd1);
        chk("c_after16_k1",  64'(dut1.r_c),  64'(C0_A));
        chk("d_after16_k1",  64'(dut1.r_d),  64'(D0_A));
        chk("c_after16_k16", 64'(dut16.r_c), 64'(C0_A));
        chk("d_after16_k16", 64'(dut16.r_d), 64'(D0_A));

        for (int i = 0; i < 16; i++) begin
            read(1,  4'(i), 1'b0, KTAB[i]);
            read(4,  4'(i), 1'b0, KTAB[i]);
            read(16, 4'(i), 1'b0, KTAB[i]);
            tick();
        end
        clear_rd();
        repeat (2) tick();

        // Decrypt order on K=1
        read(1, 4'd0,  1'b1, KTAB[15]); tick();
        read(1, 4'd15, 1'b1, KTAB[0]);  tick();
        read(1, 4'd5,  1'b1, KTAB[10]); tick();
        clear_rd();
        repeat (2) tick();

        // Restart from DONE; start and key change mid-GEN are ignored; read while busy refused
        if1.key_in = KEY_A; if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        repeat (4) tick();
        if1.start = 1'b1; if1.key_in = KEY_B;
        set_rd(1, 1'b1, 4'd3, 1'b0);
        tick();
        if1.start = 1'b0;
        clear_rd();
        chk("busy_mid_gen",        64'(if1.busy), 64'd1);
        chk("ready_mid_gen",       64'(if1.ready), 64'd0);
        chk("rd_valid_while_busy", 64'(if1.rd_valid), 64'd0);
        chk("rd_key_hold",         64'(if1.rd_key), 64'(KTAB[10]));
        wait_ready1(5, c);
        chk("latency_ignored_start", 64'(c), 64'd16);
        read(1, 4'd0,  1'b0, KTAB[0]);  tick();
        read(1, 4'd3,  1'b0, KTAB[3]);  tick();
        read(1, 4'd8,  1'b0, KTAB[8]);  tick();
        read(1, 4'd15, 1'b0, KTAB[15]); tick();
        clear_rd();
        repeat (2) tick();

        // Start with simultaneous read: read served from the pre-edge table
        if1.key_in = '0; if1.start = 1'b1;
        read(1, 4'd0, 1'b0, KTAB[0]);
        tick();
        if1.start = 1'b0;
        clear_rd();
        wait_ready1(0, c);
        chk("latency_zero_key", 64'(c), 64'd16);
        chk("c_zero_key", 64'(dut1.r_c), 64'd0);
        for (int i = 0; i < 16; i++) begin
            read(1, 4'(i), 1'b0, 48'h0);
            tick();
        end
        clear_rd();
        repeat (2) tick();

        // Reset mid-GEN
        if1.key_in = KEY_A; if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        #1;
        chk("midgen_rst_busy",     64'(if1.busy), 64'd0);
        chk("midgen_rst_ready",    64'(if1.ready), 64'd0);
        chk("midgen_rst_rd_valid", 64'(if1.rd_valid), 64'd0);
        for (int e = 0; e < 16; e++) begin
            chk("midgen_rst_table", 64'(dut1.w_table[e]), 64'd0);
        end
        tick();
        rst = 1'b0;
        tick();
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        wait_ready1(0, c);
        chk("latency_after_rst", 64'(c), 64'd16);
        read(1, 4'd0,  1'b0, KTAB[0]);  tick();
        read(1, 4'd15, 1'b1, KTAB[0]);  tick();
        read(1, 4'd15, 1'b0, KTAB[15]); tick();
        clear_rd();
        repeat (3) tick();

        chk("scoreboard_empty_k1",  64'(q1.size()),  64'd0);
        chk("scoreboard_empty_k4",  64'(q4.size()),  64'd0);
        chk("scoreboard_empty_k16", 64'(q16.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
